// File: rtl/dcj11_pkg.sv
// rtl/dcj11_pkg.sv - DCJ11 bus codes, state enum and AIO decode helpers
package dcj11_pkg;

  // AIO codes
  localparam logic [3:0] NIO           = 4'b1111;
  localparam logic [3:0] GP_READ       = 4'b1110;
  localparam logic [3:0] INTERRUPT_ACK = 4'b1101;
  localparam logic [3:0] REQEST_READ   = 4'b1100;
  localparam logic [3:0] RMW_NOLOCK    = 4'b1011;
  localparam logic [3:0] RMW_BUSLOCK   = 4'b1010;
  localparam logic [3:0] DATA_READ     = 4'b1001;
  localparam logic [3:0] DEMAND_READ   = 4'b1000;
  localparam logic [3:0] GP_WRITE      = 4'b0101;
  localparam logic [3:0] BYTE_WRITE    = 4'b0011;
  localparam logic [3:0] WORD_WRITE    = 4'b0001;

  // Bank select
  localparam logic [1:0] BS_MEM = 2'b00;
  localparam logic [1:0] BS_SYS = 2'b01;
  localparam logic [1:0] BS_EXT = 2'b10;
  localparam logic [1:0] BS_INT = 2'b11;

  // General-purpose codes carried on DAL<7:0>
  localparam logic [7:0] POWER_UP0 = 8'o000;
  localparam logic [7:0] POWER_UP2 = 8'o002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ALE,
    ST_STRB,
    ST_SCTL,
    ST_END
  } bus_state_e;

  // Everything the master drives onto the bus, registered as one word
  typedef struct packed {
    logic [3:0]  aio;
    logic [1:0]  bs;
    logic [5:0]  dal_hi;
    logic [15:0] dal_lo;
    logic        dal_oe;
    logic        ale_n;
    logic        strb_n;
    logic        bufctl_n;
    logic        sctl_n;
  } bus_drive_t;

  localparam bus_drive_t BUS_IDLE = '{
    aio: NIO, bs: 2'b00, dal_hi: 6'd0, dal_lo: 16'd0, dal_oe: 1'b0,
    ale_n: 1'b1, strb_n: 1'b1, bufctl_n: 1'b1, sctl_n: 1'b1
  };

  function automatic logic is_read(input logic [3:0] code);
    case (code)
      GP_READ, INTERRUPT_ACK, REQEST_READ, RMW_NOLOCK,
      RMW_BUSLOCK, DATA_READ, DEMAND_READ: is_read = 1'b1;
      default:                             is_read = 1'b0;
    endcase
  endfunction

  function automatic logic is_write(input logic [3:0] code);
    case (code)
      GP_WRITE, BYTE_WRITE, WORD_WRITE: is_write = 1'b1;
      default:                          is_write = 1'b0;
    endcase
  endfunction

  function automatic logic is_gp(input logic [3:0] code);
    is_gp = (code == GP_READ) || (code == GP_WRITE);
  endfunction

endpackage

// File: rtl/dcj11_bus_master_if.sv
// rtl/dcj11_bus_master_if.sv - J11 external bus signal bundle
interface dcj11_bus_master_if;
  logic [3:0]  aio;
  logic [1:0]  bs;
  logic [5:0]  dal_hi;
  logic [15:0] dal_lo_out;
  logic        dal_lo_oe;
  logic [15:0] dal_lo_in;
  logic        ale_n;
  logic        strb_n;
  logic        bufctl_n;
  logic        sctl_n;
  logic        nxm_n;

  modport master (
    output aio, bs, dal_hi, dal_lo_out, dal_lo_oe,
    output ale_n, strb_n, bufctl_n, sctl_n,
    input  dal_lo_in, nxm_n
  );

  modport slave (
    input  aio, bs, dal_hi, dal_lo_out, dal_lo_oe,
    input  ale_n, strb_n, bufctl_n, sctl_n,
    output dal_lo_in, nxm_n
  );
endinterface

// File: rtl/dcj11_bus_master.sv
// rtl/dcj11_bus_master.sv - DCJ11 bus-cycle initiator
module dcj11_bus_master
  import dcj11_pkg::*;
#(
  parameter int ADDR_CYC = 2,
  parameter int ALE_CYC  = 2,
  parameter int STRB_CYC = 3,
  parameter int SCTL_CYC = 3,
  parameter int REC_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_aio,
  input  logic [1:0]         req_bs,
  input  logic [21:0]        req_addr,
  input  logic [15:0]        req_wdata,
  output logic               rsp_valid,
  output logic [15:0]        rsp_rdata,
  output logic               rsp_nxm,
  dcj11_bus_master_if.master bus
);

  localparam logic [3:0] ADDR_LOAD = 4'(ADDR_CYC - 1);
  localparam logic [3:0] ALE_LOAD  = 4'(ALE_CYC - 1);
  localparam logic [3:0] STRB_LOAD = 4'(STRB_CYC - 1);
  localparam logic [3:0] SCTL_LOAD = 4'(SCTL_CYC - 1);
  localparam logic [3:0] REC_LOAD  = 4'(REC_CYC - 1);

  bus_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  aio_q;
  logic [1:0]  bs_q;
  logic [21:0] addr_q;
  logic [15:0] wdata_q;
  bus_drive_t  drv_q, drv_d;
  logic        ready_d;
  logic        rsp_fire;
  logic        accept;
  logic [3:0]  c_aio;
  logic [1:0]  c_bs;
  logic [21:0] c_addr;
  logic [15:0] c_wdata;

  assign accept = (state_q == ST_IDLE) && req_valid;

  // Outputs are decoded from the next state, so the request being accepted
  // must be visible before it lands in the holding registers.
  assign c_aio   = accept ? req_aio   : aio_q;
  assign c_bs    = accept ? req_bs    : bs_q;
  assign c_addr  = accept ? req_addr  : addr_q;
  assign c_wdata = accept ? req_wdata : wdata_q;

  // Phase sequencing and next-cycle bus drive values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rsp_fire = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_ADDR;
        cnt_d   = ADDR_LOAD;
      end
      ST_ADDR: if (cnt_q == 4'd0) begin
        state_d = ST_ALE;
        cnt_d   = ALE_LOAD;
      end else cnt_d = cnt_q - 4'd1;
      ST_ALE: if (cnt_q == 4'd0) begin
        if (is_read(aio_q) || is_write(aio_q)) begin
          state_d = ST_STRB;
          cnt_d   = STRB_LOAD;
        end else begin
          state_d  = ST_END;
          cnt_d    = REC_LOAD;
          rsp_fire = 1'b1;
        end
      end else cnt_d = cnt_q - 4'd1;
      ST_STRB: if (cnt_q == 4'd0) begin
        state_d = ST_SCTL;
        cnt_d   = SCTL_LOAD;
      end else cnt_d = cnt_q - 4'd1;
      ST_SCTL: if (cnt_q == 4'd0) begin
        state_d  = ST_END;
        cnt_d    = REC_LOAD;
        rsp_fire = 1'b1;
      end else cnt_d = cnt_q - 4'd1;
      ST_END: if (cnt_q == 4'd0) begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end else cnt_d = cnt_q - 4'd1;
      default: state_d = ST_IDLE;
    endcase

    drv_d   = BUS_IDLE;
    ready_d = 1'b0;
    case (state_d)
      ST_IDLE: ready_d = 1'b1;
      ST_ADDR, ST_ALE: begin
        drv_d.aio    = c_aio;
        drv_d.bs     = c_bs;
        drv_d.dal_hi = c_addr[21:16];
        drv_d.dal_lo = is_gp(c_aio) ? {8'h00, c_addr[7:0]} : c_addr[15:0];
        drv_d.dal_oe = 1'b1;
        drv_d.ale_n  = (state_d != ST_ALE);
      end
      ST_STRB, ST_SCTL: begin
        drv_d.aio    = c_aio;
        drv_d.bs     = c_bs;
        drv_d.dal_hi = c_addr[21:16];
        drv_d.strb_n = 1'b0;
        drv_d.sctl_n = (state_d != ST_SCTL);
        if (is_write(c_aio)) begin
          drv_d.dal_lo = c_wdata;
          drv_d.dal_oe = 1'b1;
        end else begin
          drv_d.bufctl_n = 1'b0;
        end
      end
      ST_END: begin
        drv_d.aio    = c_aio;
        drv_d.bs     = c_bs;
        drv_d.dal_hi = c_addr[21:16];
      end
      default: ;
    endcase
  end

  // State, request holding registers, registered bus drive and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      aio_q     <= NIO;
      bs_q      <= 2'b00;
      addr_q    <= 22'd0;
      wdata_q   <= 16'd0;
      drv_q     <= BUS_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
      rsp_nxm   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drv_q     <= drv_d;
      req_ready <= ready_d;
      rsp_valid <= rsp_fire;
      if (accept) begin
        aio_q   <= req_aio;
        bs_q    <= req_bs;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (rsp_fire) begin
        if (state_q == ST_SCTL) begin
          rsp_nxm   <= ~bus.nxm_n;
          rsp_rdata <= (is_read(aio_q) && bus.nxm_n) ? bus.dal_lo_in : 16'd0;
        end else begin
          rsp_nxm   <= 1'b0;
          rsp_rdata <= 16'd0;
        end
      end
    end
  end

  assign bus.aio        = drv_q.aio;
  assign bus.bs         = drv_q.bs;
  assign bus.dal_hi     = drv_q.dal_hi;
  assign bus.dal_lo_out = drv_q.dal_lo;
  assign bus.dal_lo_oe  = drv_q.dal_oe;
  assign bus.ale_n      = drv_q.ale_n;
  assign bus.strb_n     = drv_q.strb_n;
  assign bus.bufctl_n   = drv_q.bufctl_n;
  assign bus.sctl_n     = drv_q.sctl_n;

endmodule

// File: tb/tb_dcj11_bus_master.sv
// tb/tb_dcj11_bus_master.sv - self-checking bench for dcj11_bus_master
module tb_dcj11_bus_master;
  import dcj11_pkg::*;

  localparam int A = 2, L = 2, S = 3, C = 3, R = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_aio;
  logic [1:0]  req_bs;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_nxm;

  int     passed = 0;
  int     total  = 0;
  longint last_accept_t;

  dcj11_bus_master_if bus();

  dcj11_bus_master #(
    .ADDR_CYC(A), .ALE_CYC(L), .STRB_CYC(S), .SCTL_CYC(C), .REC_CYC(R)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aio(req_aio), .req_bs(req_bs), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nxm(rsp_nxm),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory/GP responder: memory below 0o160000 in BS_MEM, GP codes always answer
  logic [15:0] resp_mem [512];
  logic [21:0] r_addr;
  logic [3:0]  r_aio;
  logic [1:0]  r_bs;
  logic        r_gp, r_exists;
  logic [15:0] r_val;

  always_comb begin
    r_gp     = (r_aio == 4'b1110) || (r_aio == 4'b0101);
    r_exists = r_gp || (r_bs == 2'b00 && r_addr < 22'o160000);
    r_val    = r_gp ? 16'o101007 + {8'h00, r_addr[7:0]} : resp_mem[r_addr[9:1]];
  end

  assign bus.nxm_n     = bus.strb_n | r_exists;
  assign bus.dal_lo_in = !bus.bufctl_n ? (r_exists ? r_val : 16'o177777) : 16'hbeef;

  always @(posedge clk) begin
    if (!bus.ale_n) begin
      r_addr <= {bus.dal_hi, bus.dal_lo_out};
      r_aio  <= bus.aio;
      r_bs   <= bus.bs;
    end
    if (!bus.sctl_n && bus.dal_lo_oe && r_exists && !r_gp) begin
      if (r_aio == 4'b0001) resp_mem[r_addr[9:1]] <= bus.dal_lo_out;
      else if (r_aio == 4'b0011) begin
        if (r_addr[0]) resp_mem[r_addr[9:1]][15:8] <= bus.dal_lo_out[15:8];
        else           resp_mem[r_addr[9:1]][7:0]  <= bus.dal_lo_out[7:0];
      end
    end
  end

  // Reference model
  logic [15:0] model_mem [512];

  function automatic bit code_rd(input logic [3:0] c);
    return c == 4'b1110 || c == 4'b1101 || c == 4'b1100 || c == 4'b1011 ||
           c == 4'b1010 || c == 4'b1001 || c == 4'b1000;
  endfunction

  function automatic bit code_wr(input logic [3:0] c);
    return c == 4'b0101 || c == 4'b0011 || c == 4'b0001;
  endfunction

  task automatic model_txn(input logic [3:0] aio, input logic [1:0] bs, input logic [21:0] addr,
                           input logic [15:0] wd, output logic [15:0] er, output logic en,
                           output int elat);
    bit rd, wr, gp, ex;
    rd = code_rd(aio);
    wr = code_wr(aio);
    gp = (aio == 4'b1110) || (aio == 4'b0101);
    ex = gp || (bs == 2'b00 && addr < 22'o160000);
    elat = (rd || wr) ? A + L + S + C + 1 : A + L + 1;
    er = 16'd0;
    en = 1'b0;
    if (rd || wr) begin
      en = !ex;
      if (rd && ex) er = gp ? 16'o101007 + {8'h00, addr[7:0]} : model_mem[addr[9:1]];
      if (wr && ex && !gp) begin
        if (aio == 4'b0011) begin
          if (addr[0]) model_mem[addr[9:1]][15:8] = wd[15:8];
          else         model_mem[addr[9:1]][7:0]  = wd[7:0];
        end else model_mem[addr[9:1]] = wd;
      end
    end
  endtask

  // Drives one request and watches the bus cycle-by-cycle against the phase timing
  task automatic do_txn(input logic [3:0] aio, input logic [1:0] bs, input logic [21:0] addr,
                        input logic [15:0] wd, input bit hold,
                        output logic [15:0] rdata, output logic nxm, output int lat,
                        output int ready_k, output int bus_err);
    bit rd, wr, gp, ale_on, strb_on, sctl_on;
    int exp_lat;
    rd = code_rd(aio);
    wr = code_wr(aio);
    gp = (aio == 4'b1110) || (aio == 4'b0101);
    exp_lat = (rd || wr) ? A + L + S + C + 1 : A + L + 1;
    lat = 0; ready_k = 0; bus_err = 0; rdata = 16'd0; nxm = 1'b0;
    req_aio = aio; req_bs = bs; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      total++;
      $display("FAIL accept_timeout req_ready=%0b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_accept_t = $time;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!hold && k == 1) req_valid = 1'b0;
      ale_on  = (k >= A + 1) && (k <= A + L);
      strb_on = (rd || wr) && (k >= A + L + 1) && (k <= A + L + S + C);
      sctl_on = (rd || wr) && (k >= A + L + S + 1) && (k <= A + L + S + C);
      if (bus.ale_n !== !ale_on) bus_err++;
      if (bus.strb_n !== !strb_on) bus_err++;
      if (bus.sctl_n !== !sctl_on) bus_err++;
      if (bus.bufctl_n !== !(strb_on && rd)) bus_err++;
      if (rsp_valid !== (k == exp_lat)) bus_err++;
      if (k <= A + L) begin
        if (bus.aio !== aio || bus.bs !== bs || bus.dal_hi !== addr[21:16]) bus_err++;
        if (bus.dal_lo_out !== (gp ? {8'h00, addr[7:0]} : addr[15:0])) bus_err++;
        if (bus.dal_lo_oe !== 1'b1) bus_err++;
      end else if (strb_on) begin
        if (wr && (bus.dal_lo_oe !== 1'b1 || bus.dal_lo_out !== wd)) bus_err++;
        if (rd && bus.dal_lo_oe !== 1'b0) bus_err++;
      end else if (bus.dal_lo_oe !== 1'b0) bus_err++;
      if (rsp_valid && lat == 0) begin
        lat = k; rdata = rsp_rdata; nxm = rsp_nxm;
      end
      if (req_ready) begin
        ready_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_aio = 4'd0; req_bs = 2'd0; req_addr = 22'd0; req_wdata = 16'd0;
    repeat (2) @(negedge clk);
    total++; if ({bus.ale_n, bus.strb_n, bus.bufctl_n, bus.sctl_n} !== 4'b1111)
      $display("FAIL rst_strobes got %b required 1111", {bus.ale_n, bus.strb_n, bus.bufctl_n, bus.sctl_n}); else passed++;
    total++; if ({bus.aio, bus.bs, bus.dal_hi, bus.dal_lo_out, bus.dal_lo_oe} !== {4'b1111, 2'b00, 6'd0, 16'd0, 1'b0})
      $display("FAIL rst_bus got aio=%b bs=%b hi=%h lo=%h oe=%b", bus.aio, bus.bs, bus.dal_hi, bus.dal_lo_out, bus.dal_lo_oe); else passed++;
    total++; if ({req_ready, rsp_valid, rsp_nxm, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'd0})
      $display("FAIL rst_handshake got ready=%b valid=%b nxm=%b rdata=%h", req_ready, rsp_valid, rsp_nxm, rsp_rdata); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    // Reset in the middle of an ADDR phase
    req_aio = DATA_READ; req_bs = BS_MEM; req_addr = 22'o001000; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.dal_lo_oe !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL rst_pre_addr got oe=%b ready=%b required 1 0", bus.dal_lo_oe, req_ready); else passed++;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    total++; if ({bus.ale_n, bus.strb_n, bus.bufctl_n, bus.sctl_n, bus.dal_lo_oe, bus.aio} !== {4'b1111, 1'b0, 4'b1111})
      $display("FAIL rst_mid_bus got %b required 1111_0_1111", {bus.ale_n, bus.strb_n, bus.bufctl_n, bus.sctl_n, bus.dal_lo_oe, bus.aio}); else passed++;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL rst_mid_hs got ready=%b valid=%b required 1 0", req_ready, rsp_valid); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++; if (seen != 0) $display("FAIL rst_no_rsp got %0d responses required 0", seen); else passed++;
  endtask

  task automatic test_data_read();
    logic [15:0] rd; logic nx; int lat, rk, be;
    do_txn(DATA_READ, BS_MEM, 22'o001000, 16'd0, 1'b0, rd, nx, lat, rk, be);
    total++; if (rd !== 16'o123456) $display("FAIL dread_data got %o required 123456", rd); else passed++;
    total++; if (nx !== 1'b0) $display("FAIL dread_nxm got %b required 0", nx); else passed++;
    total++; if (lat != 11) $display("FAIL dread_latency got %0d required 11", lat); else passed++;
    total++; if (rk != 12) $display("FAIL dread_ready got %0d required 12", rk); else passed++;
    total++; if (be != 0) $display("FAIL dread_bus got %0d bad cycles required 0", be); else passed++;
  endtask

  task automatic test_gp_read();
    logic [15:0] rd; logic nx; int lat, rk, be;
    do_txn(GP_READ, BS_SYS, {14'd0, POWER_UP0}, 16'd0, 1'b0, rd, nx, lat, rk, be);
    total++; if (rd !== 16'o101007) $display("FAIL gpread_data got %o required 101007", rd); else passed++;
    total++; if (nx !== 1'b0) $display("FAIL gpread_nxm got %b required 0", nx); else passed++;
    total++; if (be != 0) $display("FAIL gpread_bus got %0d bad cycles required 0", be); else passed++;
  endtask

  task automatic test_write_nxm();
    logic [15:0] rd; logic nx; int lat, rk, be;
    do_txn(WORD_WRITE, BS_MEM, 22'o160000, 16'o052525, 1'b0, rd, nx, lat, rk, be);
    total++; if (nx !== 1'b1) $display("FAIL wnxm_nxm got %b required 1", nx); else passed++;
    total++; if (rd !== 16'd0) $display("FAIL wnxm_data got %o required 0", rd); else passed++;
    total++; if (be != 0) $display("FAIL wnxm_bus got %0d bad cycles required 0", be); else passed++;
    total++; if (lat != 11) $display("FAIL wnxm_latency got %0d required 11", lat); else passed++;
  endtask

  task automatic test_nio_then_read();
    logic [15:0] rd; logic nx; int lat, rk, be;
    do_txn(NIO, BS_MEM, 22'o000100, 16'd0, 1'b0, rd, nx, lat, rk, be);
    total++; if (lat != 5) $display("FAIL nio_latency got %0d required 5", lat); else passed++;
    total++; if (rk != 6) $display("FAIL nio_ready got %0d required 6", rk); else passed++;
    total++; if (nx !== 1'b0 || rd !== 16'd0) $display("FAIL nio_rsp got nxm=%b rdata=%o required 0 0", nx, rd); else passed++;
    total++; if (be != 0) $display("FAIL nio_bus got %0d bad cycles required 0", be); else passed++;
    do_txn(DATA_READ, BS_EXT, 22'd0, 16'd0, 1'b0, rd, nx, lat, rk, be);
    total++; if (nx !== 1'b1) $display("FAIL extread_nxm got %b required 1", nx); else passed++;
    total++; if (rd !== 16'd0) $display("FAIL extread_data got %o required 0", rd); else passed++;
    total++; if (be != 0) $display("FAIL extread_bus got %0d bad cycles required 0", be); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, er; logic nx, en; int lat, rk, be, elat;
    logic [21:0] a;
    longint t_prev;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      a = 22'($urandom_range(0, 1023));
      model_txn(DATA_READ, BS_MEM, a, 16'd0, er, en, elat);
      do_txn(DATA_READ, BS_MEM, a, 16'd0, 1'b1, rd, nx, lat, rk, be);
      total++; if (rd !== er) $display("FAIL b2b_data[%0d] got %o required %o", i, rd, er); else passed++;
      total++; if (rk != 12 || be != 0) $display("FAIL b2b_ready[%0d] got k=%0d err=%0d required 12 0", i, rk, be); else passed++;
      if (i > 0) begin
        total++; if (last_accept_t - t_prev != 120)
          $display("FAIL b2b_period[%0d] got %0d ns required 120", i, last_accept_t - t_prev); else passed++;
      end
      t_prev = last_accept_t;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] rd, er, wd; logic nx, en; int lat, rk, be, elat;
    logic [3:0] aio; logic [1:0] bs; logic [21:0] a;
    for (int i = 0; i < 30; i++) begin
      aio = 4'($urandom_range(0, 15));
      bs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : BS_MEM;
      a   = ($urandom_range(0, 5) == 0) ? 22'($urandom) : 22'($urandom_range(0, 1023));
      wd  = 16'($urandom);
      model_txn(aio, bs, a, wd, er, en, elat);
      do_txn(aio, bs, a, wd, 1'b0, rd, nx, lat, rk, be);
      total++; if (rd !== er) $display("FAIL rnd_data[%0d] aio=%b got %o required %o", i, aio, rd, er); else passed++;
      total++; if (nx !== en) $display("FAIL rnd_nxm[%0d] aio=%b got %b required %b", i, aio, nx, en); else passed++;
      total++; if (lat != elat) $display("FAIL rnd_latency[%0d] aio=%b got %0d required %0d", i, aio, lat, elat); else passed++;
      total++; if (rk != elat + R) $display("FAIL rnd_ready[%0d] got %0d required %0d", i, rk, elat + R); else passed++;
      total++; if (be != 0) $display("FAIL rnd_bus[%0d] aio=%b got %0d bad cycles required 0", i, aio, be); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      resp_mem[i]  = v;
      model_mem[i] = v;
    end
    resp_mem[22'o001000 >> 1]  = 16'o123456;
    model_mem[22'o001000 >> 1] = 16'o123456;
    test_reset();
    test_data_read();
    test_gp_read();
    test_write_nxm();
    test_nio_then_read();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dcj11_bus_master.md
# dcj11_bus_master

- Synthesizable DCJ11 bus-cycle initiator: turns a simple valid/ready request into a complete J11 external bus transaction.
- Drives AIO, BS, DAL<21:0>, ALE_N, STRB_N, BUFCTL_N and SCTL_N. Samples DAL<15:0> and NXM_N, then returns a response.
- Stands in for the CPU during board bring-up and in benches, exercising the memory/GP responder on the same bus.

## Interface
Parameters:
- ADDR_CYC, 2: cycles address/AIO/BS are driven before ALE_N falls (1–15)
- ALE_CYC, 2: cycles ALE_N held low before STRB_N falls (1–15)
- STRB_CYC, 3: cycles STRB_N low before SCTL_N falls (1–15)
- SCTL_CYC, 3: cycles SCTL_N low (1–15)
- REC_CYC, 1: recovery cycles, all strobes high, before next accept (1–15)

Ports:
- clk  in  1  bus clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_aio  in  4  AIO code
- req_bs  in  2  bank select
- req_addr  in  22  physical address; GP requests use [7:0] as GP code
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  16  read data (0 for writes, NIO, or NXM)
- rsp_nxm  out  1  NXM_N was sampled low
- aio  out  4; bs  out  2; dal_hi  out  6
- dal_lo_out  out  16; dal_lo_oe  out  1  DAL<15:0> drive value and enable
- dal_lo_in  in  16  DAL<15:0> as seen on the bus
- ale_n, strb_n, bufctl_n, sctl_n  out  1 each
- nxm_n  in  1  responder abort

## Operation
- States: IDLE → ADDR → ALE → STRB → SCTL → END → IDLE. Each state has a 4-bit down-counter loaded with its *_CYC parameter.
- Accept: in IDLE, req_valid high with req_ready high latches the request and enters ADDR.
- ADDR:
  - aio and bs take the request values.
  - dal_hi and dal_lo_out take the address; dal_lo_oe is 1.
  - A GP read or GP write puts {8'o0, code} on DAL<15:0>.
- ALE: ale_n is 0; the address is still driven.
- Reads (AIO 1110, 1101, 1100, 1011, 1010, 1001, 1000):
  - From STRB onward, dal_lo_oe is 0.
  - bufctl_n is 0 during STRB and SCTL.
- Writes (AIO 0101, 0011, 0001):
  - In STRB and SCTL, dal_lo_out is req_wdata and dal_lo_oe is 1.
  - bufctl_n stays 1.
- STRB: strb_n is 0.
- SCTL: strb_n and sctl_n are 0.
- Sampling: on the edge leaving SCTL, nxm_n and dal_lo_in are captured.
  - rsp_nxm = ~nxm_n.
  - rsp_rdata = (read && nxm_n) ? dal_lo_in : 0.
- END: all strobes are 1 and dal_lo_oe is 0.
  - rsp_valid is 1 in the first END cycle only.
  - After REC_CYC cycles, the block returns to IDLE.
- NIO (1111): goes ADDR → ALE → END. STRB and SCTL are skipped, rsp_nxm = 0, rsp_rdata = 0.
- Undefined AIO codes are handled as NIO.
- Reset values: ale_n, strb_n, bufctl_n, sctl_n = 1. aio = 4'b1111. bs, dal_hi, dal_lo_out = 0. dal_lo_oe = 0. rsp_valid, rsp_nxm, rsp_rdata = 0. req_ready = 1.
- Reset mid-transaction: immediate return to reset values. The in-flight request is dropped and no rsp_valid is issued.
- Request inputs are ignored outside IDLE.

## Timing
- Accept at edge E0.
- Read/write:
  - rsp_valid high in the cycle after edge E0+ADDR+ALE+STRB+SCTL (defaults: E0+10).
  - req_ready high again after edge E0+10+REC_CYC (defaults: E0+11).
  - Minimum back-to-back period: ADDR+ALE+STRB+SCTL+REC+1 = 12 cycles at defaults, counting the IDLE accept cycle.
- NIO: rsp_valid after edge E0+ADDR+ALE.
- Outputs are registered; no combinational path from inputs to outputs.
- nxm_n and dal_lo_in are sampled synchronously with clk. The responder must be stable by the last SCTL cycle.

## Structure
- Package dcj11_pkg:
  - AIO code constants (NIO, GP_READ, INTERRUPT_ACK, REQEST_READ, RMW_NOLOCK, RMW_BUSLOCK, DATA_READ, DEMAND_READ, GP_WRITE, BYTE_WRITE, WORD_WRITE).
  - BS constants (BS_MEM, BS_SYS, BS_EXT, BS_INT).
  - GP codes (POWER_UP0, POWER_UP2).
  - Bus state enum.
  - Functions is_read(aio) and is_write(aio).
- No sub-module; the phase counter lives inline.

## Test plan
- Reset: assert rst_n low mid-ADDR → all strobes 1, dal_lo_oe 0, aio 1111, req_ready 1, no rsp_valid.
- Data read, BS_MEM, addr 0o001000, responder returns 0o123456 → strobe sequence correct, bufctl_n low 6 cycles, rsp_valid at E0+10 with rdata 0o123456 and nxm 0.
- GP read, code 0o000, against the memory/GP responder → rsp_rdata 0o101007, rsp_nxm 0.
- Word write, BS_MEM, addr 0o160000, data 0o052525 → DAL driven through SCTL, responder pulls nxm_n low, rsp_nxm 1, rsp_rdata 0.
- NIO, then immediate data read of BS_EXT addr 0 → NIO has no STRB/SCTL pulse and rsp_valid at E0+4; the read returns rsp_nxm 1.
- Back-to-back reads with req_valid held high → accepts exactly 12 cycles apart; req_ready low throughout each transaction.
